// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM bus arbiter and its winner-select helper.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      GAP    = 2'd3
   } arb_state_t;

   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

   function automatic int max2(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/ram_bus_arbiter_rr_pick2.sv
// Combinational two-way winner select: fixed priority to A, or alternate on a tie
// using the last-served flag.
module rr_pick2
   import ram_arb_pkg::*;
(
   input  logic a_req,
   input  logic b_req,
   input  logic last,
   input  logic prio_a,
   output logic any_req,
   output logic pick
);

   always_comb begin
      any_req = a_req | b_req;
      pick    = GRANT_A;
      // B wins when alone, or on a tie when round-robin and A was served last.
      if (b_req && !(a_req && (prio_a || (last == GRANT_B)))) begin
         pick = GRANT_B;
      end
   end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares the static-RAM style controller bus between two requesters: one access at
// a time, cs held for a fixed window, read data captured and a one-cycle ack returned.
module ram_bus_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W  = 25,
   parameter int ACC_CYC = 4,
   parameter int GAP_CYC = 1,
   parameter int PRIO_A  = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              a_req_i,
   input  logic              b_req_i,
   input  logic              a_we_i,
   input  logic              b_we_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [7:0]        a_data_i,
   input  logic [7:0]        b_data_i,
   output logic              a_ack_o,
   output logic              b_ack_o,
   output logic [7:0]        a_data_o,
   output logic [7:0]        b_data_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_data_o,
   input  logic [7:0]        mem_data_i,
   output logic              mem_cs_o,
   output logic              mem_oe_o,
   output logic              mem_we_o,
   output logic              grant_o
);

   localparam int               CNT_W    = $clog2(max2(ACC_CYC, GAP_CYC) + 1);
   localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACC_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic             PRIO_BIT = (PRIO_A != 0);
   localparam logic             HAS_GAP  = (GAP_CYC > 0);

   arb_state_t       state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             last_reg;
   logic             any_req;
   logic             pick;

   rr_pick2 u_pick (
      .a_req   (a_req_i),
      .b_req   (b_req_i),
      .last    (last_reg),
      .prio_a  (PRIO_BIT),
      .any_req (any_req),
      .pick    (pick)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         last_reg   <= GRANT_B;
         a_ack_o    <= 1'b0;
         b_ack_o    <= 1'b0;
         a_data_o   <= 8'h00;
         b_data_o   <= 8'h00;
         mem_addr_o <= '0;
         mem_data_o <= 8'h00;
         mem_cs_o   <= 1'b0;
         mem_oe_o   <= 1'b0;
         mem_we_o   <= 1'b0;
         grant_o    <= GRANT_A;
      end else begin
         a_ack_o <= 1'b0;
         b_ack_o <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  grant_o  <= pick;
                  last_reg <= pick;
                  if (pick == GRANT_B) begin
                     mem_addr_o <= b_addr_i;
                     mem_data_o <= b_data_i;
                     mem_we_o   <= b_we_i;
                     mem_oe_o   <= ~b_we_i;
                  end else begin
                     mem_addr_o <= a_addr_i;
                     mem_data_o <= a_data_i;
                     mem_we_o   <= a_we_i;
                     mem_oe_o   <= ~a_we_i;
                  end
                  mem_cs_o  <= 1'b1;
                  cnt_reg   <= ACC_LOAD;
                  state_reg <= ACCESS;
               end
            end
            ACCESS: begin
               // Read data is sampled on the last edge cs is still asserted.
               if (cnt_reg == '0) begin
                  mem_cs_o <= 1'b0;
                  mem_oe_o <= 1'b0;
                  mem_we_o <= 1'b0;
                  if (grant_o == GRANT_B) begin
                     b_ack_o <= 1'b1;
                     if (!mem_we_o) b_data_o <= mem_data_i;
                  end else begin
                     a_ack_o <= 1'b1;
                     if (!mem_we_o) a_data_o <= mem_data_i;
                  end
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            DONE: begin
               if (HAS_GAP) begin
                  cnt_reg   <= GAP_LOAD;
                  state_reg <= GAP;
               end else begin
                  state_reg <= IDLE;
               end
            end
            GAP: begin
               if (cnt_reg == '0) state_reg <= IDLE;
               else               cnt_reg   <= cnt_reg - 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
